// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
    parameter int unsigned           WIDTH      = 96,
    parameter logic [WIDTH-1:0]      RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             accept;
    logic             consume;

    assign consume = main_valid_q && out_ready;
    assign accept  = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_ready_q,   in_ready_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (consume) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (accept && consume) begin
                main_data_d = in_data;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (accept) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
        end
        // Registered ready: depends only on next-state skid occupancy, never on out_ready.
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
            // NOTE: skid data is reset even though it is qualified by skid_valid,
            // so no X can ever be copied into main.
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
        end else if (consume) begin
            main_valid_d = 1'b0;
        end
    end

    assign in_ready  = !main_valid_q || out_ready;
    assign occupancy = {1'b0, main_valid_q};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_DATA;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid buffer. It replaces the fixed, enable-only IF/ID register of the pipelined CPU. It can be instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying an arbitrary payload such as {pc, instr}. Stalls come from downstream back-pressure; branch-taken kill is done with `flush`.

## Interface
- `WIDTH`, default 96: payload width in bits (64-bit pc + 32-bit instr).
- `RESET_DATA`, default 0: value `out_data` takes on reset.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: upstream offers `in_data`.
- `in_ready` output, 1: stage accepts a word this cycle.
- `in_data` input, WIDTH: upstream payload.
- `out_valid` output, 1: `out_data` holds a live word.
- `out_ready` input, 1: downstream consumes `out_data` this cycle.
- `out_data` output, WIDTH: payload to the next stage.
- `flush` input, 1: discard all held words (branch taken / exception).
- `occupancy` output, 2: number of words held (0..2).

## Operation
- Accept occurs when `in_valid && in_ready`; consume occurs when `out_valid && out_ready`.
- Storage consists of a main register (drives `out_data`) and a skid register (only with SKID, see Configuration).
- States:
  - EMPTY (occ 0): accept goes to FULL, main is loaded.
  - FULL (occ 1):
    - accept and consume: stay FULL, main is reloaded.
    - consume only: go to EMPTY.
    - accept only: go to SKID, skid is loaded (SKID build only; the non-SKID build cannot accept here, see `in_ready`).
  - SKID (occ 2): `in_ready`=0. Consume moves skid into main and goes to FULL.
- `in_ready`:
  - SKID build: `in_ready` = !skid_valid. It is a pure register output with no combinational path from `out_ready`.
  - Non-SKID build: `in_ready` = !out_valid || out_ready.
- `out_valid` = main_valid; `occupancy` = main_valid + skid_valid.
- `flush` has priority over everything:
  - Next state is EMPTY.
  - A word accepted in the same cycle is discarded.
  - A consume in the same cycle still counts downstream; the word is then gone.
- `out_data` holds its last value when `out_valid`=0. Downstream must qualify it with `out_valid`.
- Words are never reordered, duplicated or dropped except by `flush`.

## Timing
- Reset (`rst`=0, asynchronous) takes effect immediately:
  - main_valid = 0, skid_valid = 0, so `out_valid`=0 and `occupancy`=0.
  - `out_data` = RESET_DATA.
  - `in_ready`=1.
  - A reset in the middle of a transfer drops all held words.
- Reset release: the first accept is possible on the first rising edge after `rst` goes high.
- Latency is 1 cycle: a word accepted at edge N is on `out_data` with `out_valid`=1 after edge N.
- Throughput is 1 word/cycle while `out_ready`=1.
- Back-pressure:
  - SKID build: after `out_ready` drops, exactly one more word is accepted; `in_ready` falls the cycle after.
  - Non-SKID build: `in_ready` falls in the same cycle as `out_ready`.
- Flush is synchronous: `out_valid`=0 after the edge where `flush`=1, and `in_ready`=1 in that following cycle.
- Simultaneous accept, consume and flush: result is EMPTY.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid register is present.
  - `in_ready` is registered.
  - `occupancy` reaches 2.
- `PIPE_STAGE_SKID_EN` undefined:
  - Skid register and SKID state are removed.
  - `in_ready` is combinational as given in Operation.
  - `occupancy` ≤ 1.
  - Functionally equivalent to an enable-gated register with `enable` = `in_ready`.

## Test plan
- Reset: hold `rst`=0 with `in_valid`=1, `in_data`=96'hA5 → `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0. Release; one edge later `out_data`=96'hA5, `out_valid`=1.
- Streaming: `out_ready`=1, feed 0x1..0x8 on consecutive cycles → identical sequence out, 1-cycle latency, no gaps, `occupancy`=1 throughout.
- Back-pressure, SKID build: stream 0x10, 0x11, 0x12 and drop `out_ready` when 0x10 is on the output → `in_ready`=0 after 0x11 is captured, `occupancy`=2, 0x12 is held upstream. Raise `out_ready` → 0x10, 0x11, 0x12 emerge in order with no loss.
- Back-pressure, non-SKID build: same stimulus → `in_ready` drops in the same cycle as `out_ready`, `occupancy` never exceeds 1.
- Flush: in SKID state (0x20 main, 0x21 skid), assert `flush` together with `in_valid` carrying 0x22 → next cycle `out_valid`=0, `occupancy`=0; 0x20, 0x21 and 0x22 never appear.
- Async reset mid-stream: drop `rst` between clock edges while `occupancy`=2 → `out_valid` and `occupancy` go to 0 without a clock edge. After release, the first new word appears after 1 cycle.
